// File: rtl/sop_sweep_pkg.sv
// Shared types and constants for the SoP truth-table sweep sequencer.
package sop_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NVEC  = 16;
  localparam int IDX_W = 4;

  // Function indices on the bank output bus (a..e).
  localparam logic [2:0] FN_A = 3'd0;
  localparam logic [2:0] FN_B = 3'd1;
  localparam logic [2:0] FN_C = 3'd2;
  localparam logic [2:0] FN_D = 3'd3;
  localparam logic [2:0] FN_E = 3'd4;

endpackage

// File: rtl/sop_sweep_ctrl_popcount16.sv
// 16-bit population count, used for the ones output and the mismatch locator.
module popcount16
  import sop_sweep_pkg::*;
(
  input  logic [NVEC-1:0] din,
  output logic [4:0]      cnt
);

  // Ripple sum of all input bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NVEC; i++) begin
      cnt = cnt + {4'd0, din[i]};
    end
  end

endmodule

// File: rtl/sop_sweep_ctrl.sv
// Truth-table sweep sequencer for a 4-input SoP function bank.
// Steps {x,y,w,z} through 0..15, holds each vector SETTLE extra cycles,
// samples the selected bank output and compares the captured table to a
// latched expected table.
// The captured table appears on truth_table ("table" is a reserved word).
// Optional macro SOP_SWEEP_MISMATCH_LOG_EN adds first_miss/miss_vld.
// state_dbg exposes the FSM state (0=IDLE 1=APPLY 2=SAMPLE 3=DONE).
// Handshake: start is sampled only in IDLE; once accepted busy stays high
// through APPLY/SAMPLE/DONE, done pulses for one cycle in DONE, and any
// start seen while busy is dropped.
module sop_sweep_ctrl
  import sop_sweep_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int NFUNC  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func_sel,
  input  logic [15:0]      exp_table,
  input  logic [NFUNC-1:0] s_in,
  output logic             x,
  output logic             y,
  output logic             w,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      truth_table,
  output logic             match,
  output logic [4:0]       ones,
`ifdef SOP_SWEEP_MISMATCH_LOG_EN
  output logic [3:0]       first_miss,
  output logic             miss_vld,
`endif
  output logic [1:0]       state_dbg
);

  localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVEC - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         settle_q;
  logic [2:0]         sel_q;
  logic [15:0]        exp_q;
  logic [15:0]        tt_q;
  logic [15:0]        tt_nxt;
  logic               match_q;
  logic               err_q;
  logic               sel_ok;

  assign sel_ok = int'(func_sel) < NFUNC;

  // Table as it will look after the current SAMPLE capture.
  always_comb begin
    tt_nxt        = tt_q;
    tt_nxt[idx_q] = s_in[sel_q];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = sel_ok ? APPLY : DONE;
      APPLY:   if (settle_q == 4'd0) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == IDX_LAST) ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef SOP_SWEEP_MISMATCH_LOG_EN
  logic [15:0] diff;
  logic [15:0] low_m1;
  logic [4:0]  low_pos;
  logic [3:0]  first_miss_q;
  logic        miss_vld_q;

  // Bits below the lowest differing bit; their count is its index.
  // With no difference low_m1 is all ones, whose count 16 truncates to 0.
  assign diff   = tt_nxt ^ exp_q;
  assign low_m1 = (diff & (~diff + 16'd1)) - 16'd1;

  popcount16 u_pc_miss (
    .din (low_m1),
    .cnt (low_pos)
  );

  // Mismatch log is captured with the final sample and cleared on a new sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_miss_q <= '0;
      miss_vld_q   <= 1'b0;
    end else if (state_q == IDLE && start && sel_ok) begin
      first_miss_q <= '0;
      miss_vld_q   <= 1'b0;
    end else if (state_q == SAMPLE && idx_q == IDX_LAST) begin
      first_miss_q <= low_pos[3:0];
      miss_vld_q   <= (diff != 16'd0);
    end
  end

  assign first_miss = first_miss_q;
  assign miss_vld   = miss_vld_q;
`endif

  // Sweep datapath: latching, settle countdown, index stepping and capture.
  // match is registered together with the last capture so it is valid
  // during the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      settle_q <= '0;
      sel_q    <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (sel_ok) begin
              sel_q    <= func_sel;
              exp_q    <= exp_table;
              tt_q     <= '0;
              match_q  <= 1'b0;
              idx_q    <= '0;
              settle_q <= SETTLE_L;
              err_q    <= 1'b0;
            end else begin
              err_q    <= 1'b1;
            end
          end
        end
        APPLY: begin
          if (settle_q != 4'd0) settle_q <= settle_q - 4'd1;
        end
        SAMPLE: begin
          tt_q <= tt_nxt;
          if (idx_q == IDX_LAST) begin
            match_q <= (tt_nxt == exp_q);
          end else begin
            idx_q    <= idx_q + 1'b1;
            settle_q <= SETTLE_L;
          end
        end
        default: ;
      endcase
    end
  end

  popcount16 u_pc_ones (
    .din (tt_q),
    .cnt (ones)
  );

  assign {x, y, w, z}  = idx_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign truth_table   = tt_q;
  assign match         = match_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Bench for sop_sweep_ctrl: a SETTLE=1 instance for the sweep table, reset,
// and busy checks, and a SETTLE=0 instance for back-to-back timing.
module tb_sop_sweep_ctrl;

  localparam int SETTLE_M = 1;
  localparam int PER_M    = SETTLE_M + 2;
  localparam int LAT_M    = 16 * PER_M;
  localparam int LAT_0    = 32;

  // Function bank a..e as truth tables, bit i = output for {x,y,w,z}=i.
  // a = x&y | w&z, b = reference pattern, c = minterm 0, d = 1, e = parity.
  localparam logic [4:0][15:0] BANK = {16'h6996, 16'hFFFF, 16'h0001, 16'h28AB, 16'hF888};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- main DUT (SETTLE=1) ----------------
  logic        start;
  logic [2:0]  func_sel;
  logic [15:0] exp_table;
  logic [4:0]  s_in;
  logic        x, y, w, z, busy, done, err, match;
  logic [15:0] truth_table;
  logic [4:0]  ones;
  logic [1:0]  state_dbg;
`ifdef SOP_SWEEP_MISMATCH_LOG_EN
  logic [3:0]  first_miss;
  logic        miss_vld;
`endif

  always_comb begin
    s_in = '0;
    for (int k = 0; k < 5; k++) s_in[k] = BANK[k][{x, y, w, z}];
  end

  sop_sweep_ctrl #(.SETTLE(SETTLE_M), .NFUNC(5)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .func_sel    (func_sel),
    .exp_table   (exp_table),
    .s_in        (s_in),
    .x           (x),
    .y           (y),
    .w           (w),
    .z           (z),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .truth_table (truth_table),
    .match       (match),
    .ones        (ones),
`ifdef SOP_SWEEP_MISMATCH_LOG_EN
    .first_miss  (first_miss),
    .miss_vld    (miss_vld),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- second DUT (SETTLE=0) ----------------
  logic        start0;
  logic [2:0]  func_sel0;
  logic [15:0] exp_table0;
  logic [4:0]  s_in0;
  logic        x0, y0, w0, z0, busy0, done0, err0, match0;
  logic [15:0] truth_table0;
  logic [4:0]  ones0;
  logic [1:0]  state_dbg0;
`ifdef SOP_SWEEP_MISMATCH_LOG_EN
  logic [3:0]  first_miss0;
  logic        miss_vld0;
`endif

  always_comb begin
    s_in0 = '0;
    for (int k = 0; k < 5; k++) s_in0[k] = BANK[k][{x0, y0, w0, z0}];
  end

  sop_sweep_ctrl #(.SETTLE(0), .NFUNC(5)) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start0),
    .func_sel    (func_sel0),
    .exp_table   (exp_table0),
    .s_in        (s_in0),
    .x           (x0),
    .y           (y0),
    .w           (w0),
    .z           (z0),
    .busy        (busy0),
    .done        (done0),
    .err         (err0),
    .truth_table (truth_table0),
    .match       (match0),
    .ones        (ones0),
`ifdef SOP_SWEEP_MISMATCH_LOG_EN
    .first_miss  (first_miss0),
    .miss_vld    (miss_vld0),
`endif
    .state_dbg   (state_dbg0)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Requests one sweep on the main DUT and returns at the negedge where done
  // is first seen. lat counts active edges from the accept edge.
  task automatic run_sweep(input logic [2:0] sel, input logic [15:0] et,
                           input bit valid, output int lat);
    int   k;
    bit   vec_bad;
    bit   busy_bad;
    @(negedge clk);
    start     = 1'b1;
    func_sel  = sel;
    exp_table = et;
    @(negedge clk);
    start    = 1'b0;
    k        = 0;
    vec_bad  = 1'b0;
    busy_bad = 1'b0;
    while (!done && k < 200) begin
      if ({x, y, w, z} !== 4'(k / PER_M)) vec_bad = 1'b1;
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    lat = k;
    if (valid) begin
      check("vec_order", 32'(vec_bad), 32'd0);
      check("busy_mid", 32'(busy_bad), 32'd0);
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] et;
    logic        e_err;
    logic [15:0] e_tbl;
    logic        e_match;
    logic [4:0]  e_ones;
    logic [3:0]  e_fm;
  } vec_t;

  vec_t vt[9];

  initial begin
    int lat;
    int ndone, first_done;
    int d1, d2, nd;
    int k;

    rst_n = 1'b0; start = 1'b0; func_sel = '0; exp_table = '0;
    start0 = 1'b0; func_sel0 = '0; exp_table0 = '0;

    // sel, exp_table, err, table, match, ones, first_miss
    vt[0] = '{3'd1, 16'h28AB, 1'b0, 16'h28AB, 1'b1, 5'd7,  4'd0};
    vt[1] = '{3'd1, 16'h28AA, 1'b0, 16'h28AB, 1'b0, 5'd7,  4'd0};
    vt[2] = '{3'd0, 16'hF888, 1'b0, 16'hF888, 1'b1, 5'd7,  4'd0};
    vt[3] = '{3'd4, 16'h6996, 1'b0, 16'h6996, 1'b1, 5'd8,  4'd0};
    vt[4] = '{3'd3, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1, 5'd16, 4'd0};
    vt[5] = '{3'd2, 16'h0000, 1'b0, 16'h0001, 1'b0, 5'd1,  4'd0};
    vt[6] = '{3'd5, 16'h1234, 1'b1, 16'h0001, 1'b0, 5'd1,  4'd0};
    vt[7] = '{3'd7, 16'hFFFF, 1'b1, 16'h0001, 1'b0, 5'd1,  4'd0};
    vt[8] = '{3'd1, 16'h28AB, 1'b0, 16'h28AB, 1'b1, 5'd7,  4'd0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_vec", 32'({x, y, w, z}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_table", 32'(truth_table), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_ones", 32'(ones), 32'd0);
    check("rst_state0", 32'(state_dbg0), 32'd0);
    rst_n = 1'b1;

    // Table-driven sweeps.
    for (int i = 0; i < 9; i++) begin
      run_sweep(vt[i].sel, vt[i].et, !vt[i].e_err, lat);
      check($sformatf("latency[%0d]", i), 32'(lat), vt[i].e_err ? 32'd0 : 32'(LAT_M));
      check($sformatf("done[%0d]", i), 32'(done), 32'd1);
      check($sformatf("busy_done[%0d]", i), 32'(busy), 32'd1);
      check($sformatf("err[%0d]", i), 32'(err), 32'(vt[i].e_err));
      check($sformatf("table[%0d]", i), 32'(truth_table), 32'(vt[i].e_tbl));
      check($sformatf("match[%0d]", i), 32'(match), 32'(vt[i].e_match));
      check($sformatf("ones[%0d]", i), 32'(ones), 32'(vt[i].e_ones));
      check($sformatf("vec_hold[%0d]", i), 32'({x, y, w, z}), 32'd15);
`ifdef SOP_SWEEP_MISMATCH_LOG_EN
      check($sformatf("miss_vld[%0d]", i), 32'(miss_vld), 32'(!vt[i].e_match));
      check($sformatf("first_miss[%0d]", i), 32'(first_miss), 32'(vt[i].e_fm));
`endif
      @(negedge clk);
      check($sformatf("done_pulse[%0d]", i), 32'(done), 32'd0);
      check($sformatf("busy_idle[%0d]", i), 32'(busy), 32'd0);
    end

    // Asynchronous reset in the middle of the sweep at vector 7.
    @(negedge clk);
    start = 1'b1; func_sel = 3'd1; exp_table = 16'h28AB;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while ({x, y, w, z} !== 4'd7 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reach_vec7", 32'({x, y, w, z}), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state_dbg), 32'd0);
    check("arst_vec", 32'({x, y, w, z}), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_table", 32'(truth_table), 32'd0);
    check("arst_match", 32'(match), 32'd0);
    check("arst_ones", 32'(ones), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(3'd1, 16'h28AB, 1'b1, lat);
    check("post_rst_latency", 32'(lat), 32'(LAT_M));
    check("post_rst_table", 32'(truth_table), 32'h28AB);
    check("post_rst_match", 32'(match), 32'd1);
    @(negedge clk);

    // Start pulses and select changes while busy are ignored.
    @(negedge clk);
    start = 1'b1; func_sel = 3'd1; exp_table = 16'h28AB;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    first_done = -1;
    for (int j = 0; j < 70; j++) begin
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = j;
      end
      start     = (j + 1 == 5) || (j + 1 == 20) || (j + 1 == 40);
      func_sel  = start ? 3'd0 : 3'd4;
      exp_table = 16'h0000;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_ndone", 32'(ndone), 32'd1);
    check("busy_first_done", 32'(first_done), 32'(LAT_M));
    check("busy_table", 32'(truth_table), 32'h28AB);
    check("busy_match", 32'(match), 32'd1);
    check("busy_end_idle", 32'(busy), 32'd0);

    // Back-to-back on the SETTLE=0 instance with start held high.
    @(negedge clk);
    start0 = 1'b1; func_sel0 = 3'd1; exp_table0 = 16'h28AB;
    d1 = -1; d2 = -1; nd = 0;
    for (int j = 0; j < 120; j++) begin
      @(negedge clk);
      if (done0) begin
        if (nd == 0) d1 = j;
        else if (nd == 1) d2 = j;
        nd++;
        if (nd == 2) start0 = 1'b0;
      end
    end
    start0 = 1'b0;
    check("b2b_first_done", 32'(d1), 32'(LAT_0));
    check("b2b_second_done", 32'(d2), 32'(2 * LAT_0 + 2));
    check("b2b_ndone", 32'(nd), 32'd2);
    check("b2b_table", 32'(truth_table0), 32'h28AB);
    check("b2b_match", 32'(match0), 32'd1);
    check("b2b_ones", 32'(ones0), 32'd7);
    check("b2b_idle", 32'(busy0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
